// File: rtl/cronometro_pkg.sv
// rtl/cronometro_pkg.sv - shared types and constants for the stopwatch controller
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } estado_t;

    localparam logic [3:0] MAX_UNITS = 4'd9;
    localparam logic [2:0] MAX_TENS  = 3'd5;

endpackage

// File: rtl/cronometro_debounce_pulso.sv
// rtl/cronometro_debounce_pulso.sv - synchroniser, debounce counter and one-shot press pulse
module debounce_pulso #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_out
);

    localparam int            CW   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_fired;
    logic          r_pulse;

    // Two-flop synchroniser, then count consecutive high samples; fire once per press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_fired <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (!r_sync2) begin
                // Release re-arms the one-shot and restarts the stability count
                r_cnt   <= '0;
                r_fired <= 1'b0;
            end else if (!r_fired) begin
                if (r_cnt == LAST) begin
                    r_pulse <= 1'b1;
                    r_fired <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign pulse_out = r_pulse;

endmodule

// File: rtl/cronometro_ctrl.sv
// rtl/cronometro_ctrl.sv - stopwatch control FSM, lap hold registers and display mux
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit STOP_AT_MAX     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic [3:0] cur_units,
    input  logic [2:0] cur_tens,
    output logic       count_en,
    output logic       count_clr,
    output logic [3:0] disp_units,
    output logic [2:0] disp_tens,
    output logic       running,
    output logic       lap_active
);

    logic       w_p_ss;
    logic       w_p_lap;
    logic       w_p_clr;
    logic       w_clr_acc;
    logic       w_ss_acc;
    logic       w_lap_acc;
    logic       w_active;
    logic       w_max_stop;
    logic       w_max_hit;
    logic       w_clr_next;
    logic       w_capture;
    estado_t    w_next;

    estado_t    r_state;
    logic       r_count_clr;
    logic [3:0] r_hold_units;
    logic [2:0] r_hold_tens;

    debounce_pulso #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk(clk), .reset(reset), .btn_in(btn_ss), .pulse_out(w_p_ss)
    );

    debounce_pulso #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk(clk), .reset(reset), .btn_in(btn_lap), .pulse_out(w_p_lap)
    );

    debounce_pulso #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .reset(reset), .btn_in(btn_clr), .pulse_out(w_p_clr)
    );

    // Same-cycle presses resolve clear over start/stop over lap
    assign w_clr_acc = w_p_clr;
    assign w_ss_acc  = w_p_ss & ~w_p_clr;
    assign w_lap_acc = w_p_lap & ~w_p_clr & ~w_p_ss;

    assign w_active   = (r_state == RUN) || (r_state == LAP);
    assign w_max_stop = STOP_AT_MAX && (cur_units == MAX_UNITS) && (cur_tens == MAX_TENS);
    assign w_max_hit  = tick & w_active & w_max_stop;
    assign w_capture  = (r_state == RUN) && (w_next == LAP);

    // State, registered clear pulse and lap hold registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count_clr  <= 1'b0;
            r_hold_units <= '0;
            r_hold_tens  <= '0;
        end else begin
            r_state     <= w_next;
            r_count_clr <= w_clr_next;
            if (w_capture) begin
                r_hold_units <= cur_units;
                r_hold_tens  <= cur_tens;
            end
        end
    end

    // Next-state decode; hitting 59 with stop enabled forces PAUSE ahead of buttons
    always_comb begin
        w_next     = r_state;
        w_clr_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_clr_acc) begin
                    w_clr_next = 1'b1;
                end else if (w_ss_acc) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_max_hit) begin
                    w_next = PAUSE;
                end else if (w_ss_acc) begin
                    w_next = PAUSE;
                end else if (w_lap_acc) begin
                    w_next = LAP;
                end
            end
            LAP: begin
                if (w_max_hit) begin
                    w_next = PAUSE;
                end else if (w_ss_acc) begin
                    w_next = PAUSE;
                end else if (w_lap_acc) begin
                    w_next = RUN;
                end
            end
            PAUSE: begin
                if (w_clr_acc) begin
                    w_next     = IDLE;
                    w_clr_next = 1'b1;
                end else if (w_ss_acc) begin
                    w_next = RUN;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs: enable on the pre-transition state, frozen digits only while in LAP
    always_comb begin
        count_en   = tick & w_active & ~w_max_stop;
        count_clr  = r_count_clr;
        running    = w_active;
        lap_active = (r_state == LAP);
        disp_units = cur_units;
        disp_tens  = cur_tens;
        if (r_state == LAP) begin
            disp_units = r_hold_units;
            disp_tens  = r_hold_tens;
        end
    end

endmodule

// File: tb/tb_cronometro_ctrl.sv
// tb/tb_cronometro_ctrl.sv - directed bench with counter models for wrap and stop-at-max builds
module tb_cronometro_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick;
    logic       btn_ss = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;

    logic [3:0] u0, u1;
    logic [2:0] t0, t1;
    logic       en0, en1, clr0, clr1, run0, run1, lap0, lap1;
    logic [3:0] du0, du1;
    logic [2:0] dt0, dt1;

    int tcnt;
    int checks = 0;
    int errors = 0;
    int n_en0, n_en1, n_clr0, n_run0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) tcnt <= 0;
        else       tcnt <= (tcnt == 19) ? 0 : tcnt + 1;
    end
    assign tick = (tcnt == 19);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            u0 <= 4'd0; t0 <= 3'd0;
        end else if (clr0) begin
            u0 <= 4'd0; t0 <= 3'd0;
        end else if (en0) begin
            if (u0 == 4'd9) begin
                u0 <= 4'd0;
                t0 <= (t0 == 3'd5) ? 3'd0 : t0 + 3'd1;
            end else begin
                u0 <= u0 + 4'd1;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            u1 <= 4'd0; t1 <= 3'd0;
        end else if (clr1) begin
            u1 <= 4'd0; t1 <= 3'd0;
        end else if (en1) begin
            if (u1 == 4'd9) begin
                u1 <= 4'd0;
                t1 <= (t1 == 3'd5) ? 3'd0 : t1 + 3'd1;
            end else begin
                u1 <= u1 + 4'd1;
            end
        end
    end

    cronometro_ctrl #(.DEBOUNCE_CYCLES(4), .STOP_AT_MAX(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .cur_units(u0), .cur_tens(t0),
        .count_en(en0), .count_clr(clr0),
        .disp_units(du0), .disp_tens(dt0),
        .running(run0), .lap_active(lap0)
    );

    cronometro_ctrl #(.DEBOUNCE_CYCLES(4), .STOP_AT_MAX(1'b1)) u_stop (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .cur_units(u1), .cur_tens(t1),
        .count_en(en1), .count_clr(clr1),
        .disp_units(du1), .disp_tens(dt1),
        .running(run1), .lap_active(lap1)
    );

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_en0  += int'(en0);
            n_en1  += int'(en1);
            n_clr0 += int'(clr0);
            n_run0 += int'(run0);
        end
    endtask

    task automatic clear_mon();
        n_en0 = 0; n_en1 = 0; n_clr0 = 0; n_run0 = 0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mask bit0 = start/stop, bit1 = lap, bit2 = clear
    task automatic press(input int mask, input int n);
        btn_ss  = mask[0];
        btn_lap = mask[1];
        btn_clr = mask[2];
        cyc(n);
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
    endtask

    task automatic wait_live(input int u, input int t, input int bound, input string tag);
        int k = 0;
        while (!(int'(u1) == u && int'(t1) == t) && k < bound) begin
            cyc(1);
            k++;
        end
        chk(tag, int'(int'(u1) == u && int'(t1) == t), 1);
    endtask

    initial begin
        clear_mon();
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("reset_count_en", int'(en0), 0);
        chk("reset_count_clr", int'(clr0), 0);
        chk("reset_running", int'(run0), 0);
        chk("reset_lap_active", int'(lap0), 0);
        chk("reset_disp_units", int'(du0), 0);
        chk("reset_disp_tens", int'(dt0), 0);

        // Glitchy press never stays high long enough
        btn_ss = 1'b1; cyc(3);
        btn_ss = 1'b0; cyc(1);
        btn_ss = 1'b1; cyc(3);
        btn_ss = 1'b0; cyc(10);
        chk("glitch_stays_idle", int'(run0), 0);

        press(1, 8); cyc(4);
        chk("start_running", int'(run0), 1);
        clear_mon(); cyc(20);
        chk("tick_enable_one_clk", n_en0, 1);

        // Long hold gives a single pulse: RUN -> PAUSE and no toggle back
        press(1, 50); cyc(4);
        chk("hold_to_pause", int'(run0), 0);
        clear_mon(); cyc(40);
        chk("hold_single_pulse", n_run0, 0);
        chk("pause_no_count", n_en0, 0);

        press(1, 8); cyc(4);
        chk("resume_running", int'(run0), 1);

        wait_live(2, 1, 600, "reach_12s");
        press(2, 8); cyc(4);
        chk("lap_active_on", int'(lap0), 1);
        chk("lap_hold_units", int'(du0), 2);
        chk("lap_hold_tens", int'(dt0), 1);
        wait_live(7, 1, 200, "reach_17s");
        chk("lap_frozen_units", int'(du0), 2);
        chk("lap_frozen_tens", int'(dt0), 1);
        press(2, 8); cyc(3);
        chk("lap_release_units", int'(du0), 7);
        chk("lap_release_tens", int'(dt0), 1);
        chk("lap_active_off", int'(lap0), 0);

        clear_mon();
        press(4, 8); cyc(4);
        chk("clr_ignored_in_run", n_clr0, 0);
        chk("still_running", int'(run0), 1);

        press(1, 8); cyc(4);
        chk("ss_to_pause", int'(run0), 0);
        clear_mon();
        press(4, 8); cyc(4);
        chk("clr_one_clk", n_clr0, 1);
        chk("clr_idle_running", int'(run0), 0);
        chk("clr_live_units", int'(u0), 0);
        chk("clr_live_tens", int'(t0), 0);

        press(1, 8); cyc(4); cyc(40);
        press(1, 8); cyc(4);
        chk("pause_again", int'(run0), 0);
        chk("pause_has_count", int'(u0 != 4'd0), 1);
        clear_mon();
        press(5, 8); cyc(4);
        chk("both_clr_one_clk", n_clr0, 1);
        chk("both_never_run", n_run0, 0);
        chk("both_live_units", int'(u0), 0);

        press(1, 8); cyc(4);
        wait_live(9, 5, 1400, "reach_59s");
        clear_mon(); cyc(20);
        chk("stop_count_en", n_en1, 0);
        chk("stop_paused", int'(run1), 0);
        chk("stop_lap_off", int'(lap1), 0);
        chk("stop_disp_units", int'(du1), 9);
        chk("stop_disp_tens", int'(dt1), 5);
        chk("wrap_count_en", n_en0, 1);
        chk("wrap_units", int'(u0), 0);
        chk("wrap_tens", int'(t0), 0);
        chk("wrap_running", int'(run0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cronometro_ctrl.md
Name: cronometro_ctrl

Overview:
Control FSM for the 00–59 s seconds counter chain: mod-10 units counter, mod-6 tens counter and two 7-segment decoders.
- Takes three raw pushbuttons (start/stop, lap, clear) and the 1 Hz tick enable from the clock divider.
- Produces count enable and synchronous clear for the counters.
- Selects live or lap-frozen digits for the decoders.
- Everything runs on the single board clock; the counters use count_en as a clock enable, never as a derived clock.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable-high clocks (post-synchroniser) before a button press is accepted.
- STOP_AT_MAX, 0: 1 = stop at 59 instead of wrapping to 00.

Ports:
- clk  in  1  board clock
- reset  in  1  asynchronous, active-high; clears all state
- tick  in  1  one-clk-wide 1 Hz enable from divider
- btn_ss  in  1  raw start/stop button, active-high, asynchronous to clk
- btn_lap  in  1  raw lap button, active-high
- btn_clr  in  1  raw clear button, active-high
- cur_units  in  4  live units digit from mod-10 counter (0–9)
- cur_tens  in  3  live tens digit from mod-6 counter (0–5)
- count_en  out  1  counter advance enable
- count_clr  out  1  synchronous clear to both counters, one clk wide
- disp_units  out  4  units digit to decoder
- disp_tens  out  3  tens digit to decoder
- running  out  1  high in RUN or LAP
- lap_active  out  1  high in LAP

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE, count_clr = 0, hold registers = 0, debouncer state = 0.
  - Outputs: count_en = 0, running = 0, lap_active = 0, disp = live inputs.
- Button conditioning:
  - Each button passes through a 2-flop synchroniser, then a debounce counter.
  - A one-clk press pulse (p_ss, p_lap, p_clr) is emitted in the clk after the synchronised level has been high for DEBOUNCE_CYCLES consecutive clks.
  - A low sample resets the counter.
  - Only one pulse per press; a new pulse requires a release (sync low) first.
- Same-cycle press priority: p_clr > p_ss > p_lap; lower-priority pulses in that cycle are discarded.
- FSM states: IDLE, RUN, LAP, PAUSE.
  - IDLE: p_ss -> RUN; p_clr -> issue count_clr, stay IDLE; p_lap ignored.
  - RUN: p_ss -> PAUSE; p_lap -> LAP and capture cur_units/cur_tens into hold registers in the same edge; p_clr ignored.
  - LAP: p_lap -> RUN (display releases to live); p_ss -> PAUSE (display releases); p_clr ignored.
  - PAUSE: p_ss -> RUN; p_clr -> IDLE with count_clr; p_lap ignored.
- count_en (combinational) = tick AND state in {RUN, LAP} AND NOT max_stop.
  - max_stop = STOP_AT_MAX AND cur_units == 9 AND cur_tens == 5.
  - Tick-to-enable latency is 0 clks.
- Max behaviour:
  - STOP_AT_MAX = 1: a tick arriving at 59 in RUN/LAP suppresses count_en and moves next state to PAUSE; display releases to live.
  - STOP_AT_MAX = 0: wrap 59 -> 00 is done by the counters; no controller action.
- count_clr is registered: high exactly one clk, in the clk after the accepted p_clr. count_en is 0 in that clk because state is IDLE.
- disp mux (combinational): LAP shows hold registers; all other states show cur_units/cur_tens.
- A tick and a state-changing pulse in the same clk: count_en is evaluated on the current (pre-transition) state.
- Reset mid-press: the debounce counter restarts. A button still held after reset deassertion produces a pulse after DEBOUNCE_CYCLES.

Decomposition:
- Shared package cronometro_pkg:
  - typedef enum logic [1:0] estado_t {IDLE, RUN, LAP, PAUSE}.
  - Constants MAX_UNITS = 9, MAX_TENS = 5.
- Sub-module debounce_pulso (parameter DEBOUNCE_CYCLES; ports clk, reset, btn_in, pulse_out), instantiated three times.
- FSM, hold registers and mux stay in cronometro_ctrl.

Test Plan (DEBOUNCE_CYCLES = 4; bench models the counters, tick every 20 clks):
- Reset release -> count_en = 0, count_clr = 0, running = 0, disp = live 0,0. Press btn_ss 8 clks -> one p_ss, running = 1. Next tick -> count_en = 1 for exactly one clk.
- Glitch: btn_ss high 3 clks, low 1, high 3 -> no pulse, state stays IDLE. btn_ss held 50 clks -> exactly one pulse.
- Lap: run to 1,2 (12 s), press lap -> disp frozen at units 2, tens 1 while live reaches 1,7 and lap_active = 1. Press lap again -> disp = live 1,7.
- Clear while RUN ignored; press ss -> PAUSE, press clr -> count_clr high exactly 1 clk, state IDLE, live reads 0,0.
- Same clk p_clr and p_ss while PAUSE -> IDLE with count_clr, no RUN.
- STOP_AT_MAX = 1: run to 5,9, next tick -> count_en stays 0, state PAUSE, display 5,9. STOP_AT_MAX = 0 -> count_en = 1 and counters wrap to 0,0.
